trap_report_arbiter: RTL and testbench

TRAP_REPORT_ARBITER -- requirements
Module: trap_report_arbiter

---
 rtl/trap_pkg.sv | 30 +++
 rtl/trap_report_arbiter_if.sv | 33 +++
 rtl/trap_report_arbiter_rr_pick.sv | 27 ++
 rtl/trap_report_arbiter.sv | 148 ++++++++++++++
 tb/tb_trap_report_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the trap report arbiter.
//   trap_state_e    - controller state encoding (IDLE, REPORT, DRAIN, HALT)
//   trap_payload_t  - one latched report (code, pc, cycle count, instr count)
//   TRAP_CODE_NONE  - mon_code value before any report has been latched
//   TRAP_CODE_TIMEOUT - code reported by the optional watchdog (TRAP_WATCHDOG_EN)
package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPORT = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALT   = 2'd3
  } trap_state_e;

  localparam logic [31:0] TRAP_CODE_NONE    = 32'hFFFF_FFFF;
  localparam logic [31:0] TRAP_CODE_TIMEOUT = 32'h0000_0003;

  typedef struct packed {
    logic [31:0] code;
    logic [63:0] pc;
    logic [63:0] cycle;
    logic [63:0] instr;
  } trap_payload_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trap_report_arbiter_if.sv
// trap_report_arbiter_if: trap sources + simulation monitor bundle.
//   src_req/src_code/src_pc/src_cycle/src_instr : per-source request and payload
//                                                 (source i payload at [W*i +: W])
//   src_ack                                      : one-cycle grant pulse per source
//   mon_trap/mon_code/mon_pc/mon_cycle/mon_instr : report strobe + latched payload
//   halted                                       : reporting finished (sticky)
// Modports: master = sources/monitor side, slave = arbiter side.
interface trap_report_arbiter_if #(
  parameter int N_SRC = 2
);
  logic [N_SRC-1:0]    src_req;
  logic [N_SRC*32-1:0] src_code;
  logic [N_SRC*64-1:0] src_pc;
  logic [N_SRC*64-1:0] src_cycle;
  logic [N_SRC*64-1:0] src_instr;
  logic [N_SRC-1:0]    src_ack;
  logic                mon_trap;
  logic [31:0]         mon_code;
  logic [63:0]         mon_pc;
  logic [63:0]         mon_cycle;
  logic [63:0]         mon_instr;
  logic                halted;

  modport master (
    output src_req, src_code, src_pc, src_cycle, src_instr,
    input  src_ack, mon_trap, mon_code, mon_pc, mon_cycle, mon_instr, halted
  );

  modport slave (
    input  src_req, src_code, src_pc, src_cycle, src_instr,
    output src_ack, mon_trap, mon_code, mon_pc, mon_cycle, mon_instr, halted
  );
endinterface

// File: rtl/trap_report_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   [N]  : request vector
//   ptr_i   [IW] : index of the last granted source
//   grant_o [N]  : one-hot grant, first request at or after ptr_i+1 (wrapping)
//   valid_o      : any request present
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);
  logic [IW:0]  sh;
  logic [N-1:0] rot;
  logic [N-1:0] low;

  // Rotate so that source ptr_i+1 lands on bit 0, isolate the lowest set
  // bit, then rotate back. Shift amount is at most N, so the doubled vector
  // covers the wrap.
  assign sh      = (IW+1)'(ptr_i) + (IW+1)'(1);
  assign rot     = N'({req_i, req_i} >> sh);
  assign low     = rot & (~rot + N'(1));
  assign grant_o = N'(({low, low} << sh) >> N);
  assign valid_o = |req_i;
endmodule

// File: rtl/trap_report_arbiter.sv
// trap_report_arbiter: collects trap requests from N_SRC sources and reports
// one at a time to a simulation monitor.
//   clk, reset : clock and synchronous active-high reset
//   bus        : trap_report_arbiter_if.slave (requests/payloads in,
//                src_ack, mon_* report and halted out)
// Flow: IDLE grants a source round-robin (src_ack pulse, payload latched),
// REPORT pulses mon_trap, DRAIN waits DRAIN_CYCLES, then HALT (STOP_ON_FIRST=1)
// or back to IDLE. All outputs are registered.
// Optional macro TRAP_WATCHDOG_EN: IDLE timeout after TIMEOUT_CYCLES cycles
// reports TRAP_CODE_TIMEOUT without acking any source.
module trap_report_arbiter
  import trap_pkg::*;
#(
  parameter int N_SRC          = 2,
  parameter int DRAIN_CYCLES   = 4,
  parameter int STOP_ON_FIRST  = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  trap_report_arbiter_if.slave bus
);
  localparam int IW = idx_width(N_SRC);
  localparam trap_state_e S_AFTER = (STOP_ON_FIRST != 0) ? S_HALT : S_IDLE;

  if (N_SRC < 1 || N_SRC > 8 || DRAIN_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("trap_report_arbiter: unsupported parameter combination");
  end

  trap_state_e   state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic          mon_trap_q, mon_trap_d;
  logic          halted_q, halted_d;
  trap_payload_t pay_q, pay_d;
  logic [31:0]   drain_q, drain_d;
`ifdef TRAP_WATCHDOG_EN
  logic [31:0]   wd_q, wd_d;
`endif

  logic [N_SRC-1:0] grant;
  logic             grant_valid;

  rr_pick #(.N(N_SRC), .IW(IW)) u_rr_pick (
    .req_i   (bus.src_req),
    .ptr_i   (last_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  // One-hot AND-OR selection of the granted payload and its index.
  trap_payload_t pay_acc [N_SRC+1];
  logic [IW-1:0] idx_acc [N_SRC+1];
  assign pay_acc[0] = '0;
  assign idx_acc[0] = '0;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    trap_payload_t pay;
    assign pay = {bus.src_code[32*gi +: 32], bus.src_pc[64*gi +: 64],
                  bus.src_cycle[64*gi +: 64], bus.src_instr[64*gi +: 64]};
    assign pay_acc[gi+1] = pay_acc[gi] | (grant[gi] ? pay : '0);
    assign idx_acc[gi+1] = idx_acc[gi] | (grant[gi] ? IW'(gi) : '0);
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ack_d      = '0;
    mon_trap_d = 1'b0;
    halted_d   = (state_q == S_HALT);
    pay_d      = pay_q;
    drain_d    = drain_q;
`ifdef TRAP_WATCHDOG_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          ack_d   = grant;
          last_d  = idx_acc[N_SRC];
          pay_d   = pay_acc[N_SRC];
          state_d = S_REPORT;
`ifdef TRAP_WATCHDOG_EN
          wd_d    = '0;
        end else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          // Counter is about to reach the limit with nothing pending.
          pay_d   = '{code: TRAP_CODE_TIMEOUT, pc: '0, cycle: '0, instr: '0};
          state_d = S_REPORT;
          wd_d    = '0;
        end else begin
          wd_d    = wd_q + 32'd1;
`endif
        end
      end
      S_REPORT: begin
        mon_trap_d = 1'b1;
        drain_d    = '0;
        state_d    = (DRAIN_CYCLES == 0) ? S_AFTER : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == 32'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          state_d = S_AFTER;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(N_SRC - 1);
      ack_q      <= '0;
      mon_trap_q <= 1'b0;
      halted_q   <= 1'b0;
      pay_q      <= '{code: TRAP_CODE_NONE, pc: '0, cycle: '0, instr: '0};
      drain_q    <= '0;
`ifdef TRAP_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      mon_trap_q <= mon_trap_d;
      halted_q   <= halted_d;
      pay_q      <= pay_d;
      drain_q    <= drain_d;
`ifdef TRAP_WATCHDOG_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign bus.src_ack   = ack_q;
  assign bus.mon_trap  = mon_trap_q;
  assign bus.mon_code  = pay_q.code;
  assign bus.mon_pc    = pay_q.pc;
  assign bus.mon_cycle = pay_q.cycle;
  assign bus.mon_instr = pay_q.instr;
  assign bus.halted    = halted_q;
endmodule

// File: tb/tb_trap_report_arbiter.sv
// tb_trap_report_arbiter: self-checking bench for trap_report_arbiter.
// Instances: A (defaults), B (STOP_ON_FIRST=0), C (DRAIN_CYCLES=0,
// STOP_ON_FIRST=0), R (3 sources, random traffic vs. reference model) and,
// with TRAP_WATCHDOG_EN defined, W (TIMEOUT_CYCLES=10).
module tb_trap_report_arbiter;
  localparam int B_DRAIN = 4;
  localparam int R_N     = 3;
  localparam int R_DRAIN = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  trap_report_arbiter_if #(.N_SRC(2))   if_a ();
  trap_report_arbiter_if #(.N_SRC(2))   if_b ();
  trap_report_arbiter_if #(.N_SRC(2))   if_c ();
  trap_report_arbiter_if #(.N_SRC(R_N)) if_r ();

  trap_report_arbiter #(.N_SRC(2)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  trap_report_arbiter #(.N_SRC(2), .DRAIN_CYCLES(B_DRAIN), .STOP_ON_FIRST(0))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  trap_report_arbiter #(.N_SRC(2), .DRAIN_CYCLES(0), .STOP_ON_FIRST(0))
    u_c (.clk(clk), .reset(reset), .bus(if_c));
  trap_report_arbiter #(.N_SRC(R_N), .DRAIN_CYCLES(R_DRAIN), .STOP_ON_FIRST(0))
    u_r (.clk(clk), .reset(reset), .bus(if_r));
`ifdef TRAP_WATCHDOG_EN
  trap_report_arbiter_if #(.N_SRC(2)) if_w ();
  trap_report_arbiter #(.N_SRC(2), .TIMEOUT_CYCLES(10))
    u_w (.clk(clk), .reset(reset), .bus(if_w));
`endif

  typedef struct {
    logic [1:0]  req;
    logic [31:0] code0;
    logic [31:0] code1;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic [1:0]  exp_ack;
    logic [31:0] exp_code;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t vecs [4];

  logic [R_N-1:0] r_req;
  logic [31:0]    r_code [R_N];
  logic [63:0]    r_pc   [R_N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_r();
    for (int i = 0; i < R_N; i++) begin
      if_r.src_code[32*i +: 32]  = r_code[i];
      if_r.src_pc[64*i +: 64]    = r_pc[i];
      if_r.src_cycle[64*i +: 64] = r_pc[i] ^ 64'h5555;
      if_r.src_instr[64*i +: 64] = r_pc[i] + 64'd7;
    end
    if_r.src_req = r_req;
  endtask

  // Round-robin reference: first requester after the last winner.
  function automatic int pick(input logic [R_N-1:0] req, input int last);
    for (int off = 1; off <= R_N; off++) begin
      int idx;
      idx = (last + off) % R_N;
      if (((req >> idx) & R_N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  initial begin
    int t;
    int n;
    int ack_t [3];
    logic [1:0] ack_v [3];
    logic bad;
    int next_free, last_g, report_k, g;
    logic [R_N-1:0] exp_ack;
    logic [31:0] m_code;
    logic [63:0] m_pc;

    vecs[0] = '{2'b01, 32'h0000_0000, 32'h0000_0011, 64'h8000_0010, 64'h1234,
                2'b01, 32'h0000_0000, 64'h8000_0010};
    vecs[1] = '{2'b10, 32'h0000_0005, 32'h0000_002A, 64'h0000_0020, 64'h8000_0100,
                2'b10, 32'h0000_002A, 64'h8000_0100};
    vecs[2] = '{2'b11, 32'h0000_0007, 32'h0000_0009, 64'h0000_0040, 64'h0000_0044,
                2'b01, 32'h0000_0007, 64'h0000_0040};
    vecs[3] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0001, 64'hFFFF_FFFF_0000_0004, 64'h8,
                2'b01, 32'hDEAD_BEEF, 64'hFFFF_FFFF_0000_0004};

    if_a.src_req = '0; if_a.src_code = '0; if_a.src_pc = '0; if_a.src_cycle = '0; if_a.src_instr = '0;
    if_b.src_req = '0; if_b.src_code = '0; if_b.src_pc = '0; if_b.src_cycle = '0; if_b.src_instr = '0;
    if_c.src_req = '0; if_c.src_code = '0; if_c.src_pc = '0; if_c.src_cycle = '0; if_c.src_instr = '0;
    r_req = '0;
    for (int i = 0; i < R_N; i++) begin r_code[i] = '0; r_pc[i] = '0; end
    drive_r();
`ifdef TRAP_WATCHDOG_EN
    if_w.src_req = '0; if_w.src_code = '0; if_w.src_pc = '0; if_w.src_cycle = '0; if_w.src_instr = '0;
`endif

    // ---- table-driven single reports on A (STOP_ON_FIRST=1, DRAIN=4)
    for (int v = 0; v < 4; v++) begin
      do_reset();
      check("rst_mon_code", 64'(if_a.mon_code), 64'hFFFF_FFFF);
      check("rst_mon_pc", if_a.mon_pc, 64'h0);
      check("rst_mon_trap", 64'(if_a.mon_trap), 64'h0);
      check("rst_ack", 64'(if_a.src_ack), 64'h0);
      check("rst_halted", 64'(if_a.halted), 64'h0);
      if_a.src_code  = {vecs[v].code1, vecs[v].code0};
      if_a.src_pc    = {vecs[v].pc1, vecs[v].pc0};
      if_a.src_cycle = {vecs[v].pc1 + 64'd1, vecs[v].pc0 + 64'd1};
      if_a.src_instr = {vecs[v].pc1 + 64'd2, vecs[v].pc0 + 64'd2};
      if_a.src_req   = vecs[v].req;
      t = 0;
      do begin tick(); t++; end while (if_a.src_ack == '0 && t < 10);
      $display("vec %0d: req=%b ack=%b after %0d cycle(s)", v, vecs[v].req, if_a.src_ack, t);
      check("vec_ack_latency", 64'(t), 64'd1);
      check("vec_ack", 64'(if_a.src_ack), 64'(vecs[v].exp_ack));
      if_a.src_req = if_a.src_req & ~if_a.src_ack;
      tick();
      check("vec_mon_trap", 64'(if_a.mon_trap), 64'h1);
      check("vec_ack_off", 64'(if_a.src_ack), 64'h0);
      check("vec_mon_code", 64'(if_a.mon_code), 64'(vecs[v].exp_code));
      check("vec_mon_pc", if_a.mon_pc, vecs[v].exp_pc);
      check("vec_mon_cycle", if_a.mon_cycle, vecs[v].exp_pc + 64'd1);
      check("vec_mon_instr", if_a.mon_instr, vecs[v].exp_pc + 64'd2);
      bad = 1'b0;
      for (int c = 2; c <= 5; c++) begin
        tick();
        if (if_a.src_ack != '0 || if_a.mon_trap) bad = 1'b1;
      end
      check("vec_drain_quiet", 64'(bad), 64'h0);
      check("vec_halted_T5", 64'(if_a.halted), 64'h0);
      tick();
      check("vec_halted_T6", 64'(if_a.halted), 64'h1);
      if_a.src_req = 2'b11;
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (if_a.src_ack != '0 || if_a.mon_trap || !if_a.halted) bad = 1'b1;
      end
      check("vec_halt_ignores_req", 64'(bad), 64'h0);
      check("vec_code_hold", 64'(if_a.mon_code), 64'(vecs[v].exp_code));
      if_a.src_req = '0;
    end

    // ---- reset in the cycle mon_trap would rise (A)
    do_reset();
    if_a.src_code = {32'h0000_0066, 32'h0000_0055};
    if_a.src_pc   = {64'h0, 64'h9000};
    if_a.src_req  = 2'b01;
    tick();
    check("rstmid_ack", 64'(if_a.src_ack), 64'h1);
    if_a.src_req = '0;
    reset = 1'b1;
    tick();
    $display("reset mid-report: mon_trap=%b mon_code=%h", if_a.mon_trap, if_a.mon_code);
    check("rstmid_mon_trap", 64'(if_a.mon_trap), 64'h0);
    check("rstmid_ack_off", 64'(if_a.src_ack), 64'h0);
    check("rstmid_mon_code", 64'(if_a.mon_code), 64'hFFFF_FFFF);
    reset = 1'b0;
    tick();
    check("rstmid_no_late_trap", 64'(if_a.mon_trap), 64'h0);
    if_a.src_req = 2'b10;
    tick();
    check("rstmid_idle_grant", 64'(if_a.src_ack), 64'h2);
    if_a.src_req = '0;
    tick();
    check("rstmid_new_trap", 64'(if_a.mon_trap), 64'h1);
    check("rstmid_new_code", 64'(if_a.mon_code), 64'h66);

    // ---- B: both requests held, alternating grants DRAIN+2 apart
    do_reset();
    if_b.src_code = {32'h0000_00A1, 32'h0000_00A0};
    if_b.src_req  = 2'b11;
    n = 0; t = 0;
    for (int i = 0; i < 3; i++) begin ack_t[i] = 0; ack_v[i] = '0; end
    while (n < 3 && t < 40) begin
      tick(); t++;
      if (if_b.src_ack != '0) begin
        ack_t[n] = t; ack_v[n] = if_b.src_ack; n++;
        $display("hold11: ack=%b at cycle %0d", if_b.src_ack, t);
      end
    end
    check("hold11_ack_count", 64'(n), 64'd3);
    check("hold11_grant0", 64'(ack_v[0]), 64'h1);
    check("hold11_grant1", 64'(ack_v[1]), 64'h2);
    check("hold11_grant2", 64'(ack_v[2]), 64'h1);
    check("hold11_gap01", 64'(ack_t[1] - ack_t[0]), 64'(B_DRAIN + 2));
    check("hold11_gap12", 64'(ack_t[2] - ack_t[1]), 64'(B_DRAIN + 2));
    check("hold11_code", 64'(if_b.mon_code), 64'hA0);
    if_b.src_req = '0;

    // ---- C: DRAIN_CYCLES=0, single request held
    do_reset();
    if_c.src_code = {32'h0000_00C1, 32'h0000_00C0};
    if_c.src_req  = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      $display("drain0 cycle %0d: ack=%b mon_trap=%b", k, if_c.src_ack, if_c.mon_trap);
      check($sformatf("drain0_ack@%0d", k), 64'(if_c.src_ack), (k % 2 == 1) ? 64'h1 : 64'h0);
      check($sformatf("drain0_trap@%0d", k), 64'(if_c.mon_trap), (k % 2 == 0) ? 64'h1 : 64'h0);
    end
    check("drain0_code", 64'(if_c.mon_code), 64'hC0);
    if_c.src_req = '0;

    // ---- R: random traffic vs. reference model
    do_reset();
    next_free = 1; last_g = R_N - 1; report_k = -1;
    m_code = 32'hFFFF_FFFF; m_pc = 64'h0;
    for (int k = 1; k <= 250; k++) begin
      tick();
      exp_ack = '0;
      if (k >= next_free && r_req != '0) begin
        g = pick(r_req, last_g);
        exp_ack = R_N'(1 << g);
        last_g = g;
        next_free = k + R_DRAIN + 2;
        report_k = k + 1;
        m_code = r_code[g];
        m_pc = r_pc[g];
        $display("rand cycle %0d: expect grant src %0d code %h", k, g, m_code);
      end
      check($sformatf("rand_ack@%0d", k), 64'(if_r.src_ack), 64'(exp_ack));
      check($sformatf("rand_trap@%0d", k), 64'(if_r.mon_trap), 64'(k == report_k));
      check($sformatf("rand_code@%0d", k), 64'(if_r.mon_code), 64'(m_code));
      check($sformatf("rand_pc@%0d", k), if_r.mon_pc, m_pc);
      for (int i = 0; i < R_N; i++) begin
        if (if_r.src_ack[i]) r_req[i] = 1'b0;
        else if (r_req[i]) begin
          if ($urandom_range(15) == 0) r_req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          r_req[i]  = 1'b1;
          r_code[i] = $urandom;
          r_pc[i]   = {$urandom, $urandom};
        end
      end
      drive_r();
    end
    r_req = '0;
    drive_r();

`ifdef TRAP_WATCHDOG_EN
    // ---- W: watchdog timeout with no requests
    do_reset();
    t = 0; bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (if_w.src_ack != '0) bad = 1'b1;
      if (if_w.mon_trap && t == 0) begin
        t = k;
        $display("watchdog: mon_trap at cycle %0d code %h", k, if_w.mon_code);
        check("wd_code", 64'(if_w.mon_code), 64'h3);
        check("wd_pc", if_w.mon_pc, 64'h0);
      end
      if (k == 15) check("wd_halted_15", 64'(if_w.halted), 64'h0);
      if (k == 16) check("wd_halted_16", 64'(if_w.halted), 64'h1);
    end
    check("wd_trap_cycle", 64'(t), 64'd11);
    check("wd_no_ack", 64'(bad), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
